// File: rtl/reg_bank_32x32.sv
// 32-entry register bank with one synchronous write port and two combinational read ports.
// Each read bit is selected from a 32-bit column vector, the input of a per-bit mux32 tree.
module reg_bank_32x32 #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [4:0]       wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [4:0]       ra1_i,
  input  logic [4:0]       ra2_i,
  output logic [WIDTH-1:0] rd1_o,
  output logic [WIDTH-1:0] rd2_o,
  output logic             wr_done_o,
  output logic [7:0]       wr_cnt_o
);

  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic             wr_done_q, wr_done_d;
  logic [7:0]       wr_cnt_q, wr_cnt_d;

  logic             wr_discard;
  logic             wr_commit;

  assign wr_discard = ZERO_REG && (wa_i == 5'd0);
  assign wr_commit  = we_i && !wr_discard;

  always_comb begin
    for (int k = 0; k < 32; k++) begin
      regs_d[k] = regs_q[k];
    end
    if (wr_commit) begin
      regs_d[wa_i] = wd_i;
    end
    wr_done_d = we_i;
    wr_cnt_d  = wr_commit ? wr_cnt_q + 8'd1 : wr_cnt_q;
  end

  // Reset wins over a same-cycle write, which is simply dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 32; k++) begin
        regs_q[k] <= '0;
      end
      wr_done_q <= 1'b0;
      wr_cnt_q  <= 8'd0;
    end else begin
      for (int k = 0; k < 32; k++) begin
        regs_q[k] <= regs_d[k];
      end
      wr_done_q <= wr_done_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign wr_done_o = wr_done_q;
  assign wr_cnt_o  = wr_cnt_q;

  // Column vectors: bit i of every register gathered into the mux32 data input for bit i.
  logic [31:0]      col1 [WIDTH];
  logic [31:0]      col2 [WIDTH];
  logic [WIDTH-1:0] mux1, mux2;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      for (int k = 0; k < 32; k++) begin
        col1[i][k] = regs_q[k][i];
        col2[i][k] = regs_q[k][i];
      end
    end
  end

  always_comb begin
    mux1 = '0;
    mux2 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mux1[i] = col1[i][ra1_i];
      mux2[i] = col2[i][ra2_i];
    end
  end

  logic byp1, byp2;
  logic zero1, zero2;

  assign byp1  = BYPASS && !rst_i && wr_commit && (wa_i == ra1_i);
  assign byp2  = BYPASS && !rst_i && wr_commit && (wa_i == ra2_i);
  assign zero1 = ZERO_REG && (ra1_i == 5'd0);
  assign zero2 = ZERO_REG && (ra2_i == 5'd0);

  always_comb begin
    if (zero1)     rd1_o = '0;
    else if (byp1) rd1_o = wd_i;
    else           rd1_o = mux1;

    if (zero2)     rd2_o = '0;
    else if (byp2) rd2_o = wd_i;
    else           rd2_o = mux2;
  end

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Bench for reg_bank_32x32: two instances (zero-reg+bypass, and plain) against an array model.
module tb_reg_bank_32x32;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        done_a, done_b;
  logic [7:0]  cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_bank_32x32 dut_a (
    .clk_i(clk), .rst_i(rst), .we_i(we), .wa_i(wa), .wd_i(wd),
    .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1_a), .rd2_o(rd2_a),
    .wr_done_o(done_a), .wr_cnt_o(cnt_a)
  );

  reg_bank_32x32 #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .we_i(we), .wa_i(wa), .wd_i(wd),
    .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1_b), .rd2_o(rd2_b),
    .wr_done_o(done_b), .wr_cnt_o(cnt_b)
  );

  // Model: cfg 0 = dut_a (zero reg, bypass), cfg 1 = dut_b (neither)
  logic [31:0] m_regs [2][32];
  logic [7:0]  m_cnt  [2];
  logic        m_done;

  function automatic logic [31:0] exp_rd(int c, logic [4:0] ra);
    bit zr = (c == 0);
    if (zr && ra == 5'd0) return 32'h0;
    if (c == 0 && !rst && we && wa == ra && !(zr && wa == 5'd0)) return wd;
    return m_regs[c][ra];
  endfunction

  task automatic tick();
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 32; k++) m_regs[c][k] = 32'h0;
        m_cnt[c] = 8'd0;
      end
    end else if (we) begin
      for (int c = 0; c < 2; c++) begin
        if (!(c == 0 && wa == 5'd0)) begin
          m_regs[c][wa] = wd;
          m_cnt[c]      = m_cnt[c] + 8'd1;
        end
      end
    end
    m_done = !rst && we;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; wa = 5'd3; wd = $urandom; ra1 = 5'd0; ra2 = 5'd0;
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    n_checks++; if (done_a !== 1'b0 || done_b !== 1'b0) begin n_fail++; $display("FAIL reset wr_done: got %b/%b want 0", done_a, done_b); end
    n_checks++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin n_fail++; $display("FAIL reset wr_cnt: got %0d/%0d want 0", cnt_a, cnt_b); end
    for (int r = 0; r < 32; r++) begin
      ra1 = 5'(r); ra2 = 5'(31 - r);
      #1;
      n_checks++;
      if (rd1_a !== 32'h0 || rd2_a !== 32'h0 || rd1_b !== 32'h0 || rd2_b !== 32'h0) begin
        n_fail++; $display("FAIL reset read ra=%0d: got %h %h %h %h want 0", r, rd1_a, rd2_a, rd1_b, rd2_b);
      end
    end
  endtask

  task automatic test_write_readback();
    for (int k = 1; k < 32; k++) begin
      we = 1'b1; wa = 5'(k); wd = 32'hA5A5_0000 + k;
      tick();
      n_checks++; if (done_a !== 1'b1 || done_b !== 1'b1) begin n_fail++; $display("FAIL wr_done after write %0d: got %b/%b want 1", k, done_a, done_b); end
    end
    we = 1'b0;
    n_checks++; if (cnt_a !== 8'd31 || cnt_b !== 8'd31) begin n_fail++; $display("FAIL readback wr_cnt: got %0d/%0d want 31", cnt_a, cnt_b); end
    for (int k = 1; k < 32; k++) begin
      ra1 = 5'(k); ra2 = 5'(32 - k);
      #1;
      n_checks++;
      if (rd1_a !== 32'hA5A5_0000 + k || rd1_b !== 32'hA5A5_0000 + k) begin
        n_fail++; $display("FAIL readback rd1 k=%0d: got %h/%h want %h", k, rd1_a, rd1_b, 32'hA5A5_0000 + k);
      end
      n_checks++;
      if (rd2_a !== 32'hA5A5_0000 + (32 - k) || rd2_b !== 32'hA5A5_0000 + (32 - k)) begin
        n_fail++; $display("FAIL readback rd2 k=%0d: got %h/%h want %h", k, rd2_a, rd2_b, 32'hA5A5_0000 + (32 - k));
      end
    end
    tick();
    n_checks++; if (done_a !== 1'b0 || cnt_a !== 8'd31) begin n_fail++; $display("FAIL idle hold: got done=%b cnt=%0d want 0/31", done_a, cnt_a); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    n_checks++; if (rd1_a !== 32'h0) begin n_fail++; $display("FAIL zero reg bypass rd1: got %h want 0", rd1_a); end
    n_checks++; if (rd1_b !== exp_rd(1, 5'd0)) begin n_fail++; $display("FAIL plain reg0 pre-edge: got %h want %h", rd1_b, exp_rd(1, 5'd0)); end
    tick();
    we = 1'b0;
    #1;
    n_checks++; if (done_a !== 1'b1 || cnt_a !== 8'd31) begin n_fail++; $display("FAIL zero reg write: got done=%b cnt=%0d want 1/31", done_a, cnt_a); end
    n_checks++; if (cnt_b !== 8'd32) begin n_fail++; $display("FAIL plain reg0 wr_cnt: got %0d want 32", cnt_b); end
    n_checks++; if (rd1_a !== 32'h0 || rd1_b !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reg0 readback: got %h/%h want 0/ffffffff", rd1_a, rd1_b); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd5; wd = 32'h1111_1111;
    tick();
    wd = 32'h2222_2222; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    n_checks++; if (rd1_a !== 32'h2222_2222 || rd2_a !== 32'h2222_2222) begin n_fail++; $display("FAIL bypass pre-edge: got %h/%h want 22222222", rd1_a, rd2_a); end
    n_checks++; if (rd1_b !== 32'h1111_1111 || rd2_b !== 32'h1111_1111) begin n_fail++; $display("FAIL no-bypass pre-edge: got %h/%h want 11111111", rd1_b, rd2_b); end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rd1_a !== 32'h2222_2222 || rd2_a !== 32'h2222_2222 || rd1_b !== 32'h2222_2222 || rd2_b !== 32'h2222_2222) begin
      n_fail++; $display("FAIL bypass post-edge: got %h %h %h %h want 22222222", rd1_a, rd2_a, rd1_b, rd2_b);
    end
  endtask

  task automatic test_reset_vs_write();
    rst = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    n_checks++; if (rd1_a !== 32'hA5A5_0007 || rd2_b !== 32'hA5A5_0007) begin n_fail++; $display("FAIL read during reset: got %h/%h want a5a50007", rd1_a, rd2_b); end
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    n_checks++; if (rd1_a !== 32'h0 || rd1_b !== 32'h0) begin n_fail++; $display("FAIL reg7 after reset: got %h/%h want 0", rd1_a, rd1_b); end
    n_checks++; if (done_a !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin n_fail++; $display("FAIL reset vs write flags: got done=%b cnt=%0d/%0d want 0/0/0", done_a, cnt_a, cnt_b); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    for (int n = 0; n < 256; n++) begin
      we = 1'b1; wa = 5'($urandom_range(1, 31)); wd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      #1;
      e = exp_rd(0, ra1);
      n_checks++; if (rd1_a !== e) begin n_fail++; $display("FAIL wrap rd1_a n=%0d ra=%0d: got %h want %h", n, ra1, rd1_a, e); end
      e = exp_rd(1, ra2);
      n_checks++; if (rd2_b !== e) begin n_fail++; $display("FAIL wrap rd2_b n=%0d ra=%0d: got %h want %h", n, ra2, rd2_b, e); end
      tick();
    end
    we = 1'b0;
    n_checks++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin n_fail++; $display("FAIL wr_cnt wrap: got %0d/%0d want 0", cnt_a, cnt_b); end
  endtask

  task automatic test_walking_one();
    logic [31:0] one;
    for (int k = 0; k < 32; k++) begin
      one = 32'h1 << k;
      we = 1'b1; wa = 5'(k); wd = one;
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      one = 32'h1 << k;
      ra1 = 5'(k); ra2 = 5'(31 - k);
      #1;
      n_checks++;
      if (rd1_a !== ((k == 0) ? 32'h0 : one) || rd1_b !== one) begin
        n_fail++; $display("FAIL walking one rd1 k=%0d: got %h/%h want %h", k, rd1_a, rd1_b, one);
      end
      n_checks++;
      if (rd2_a !== exp_rd(0, ra2) || rd2_b !== (32'h1 << (31 - k))) begin
        n_fail++; $display("FAIL walking one rd2 k=%0d: got %h/%h want %h/%h", k, rd2_a, rd2_b, exp_rd(0, ra2), 32'h1 << (31 - k));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 24) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      #1;
      e = exp_rd(0, ra1);
      n_checks++; if (rd1_a !== e) begin n_fail++; $display("FAIL random rd1_a n=%0d: got %h want %h", n, rd1_a, e); end
      e = exp_rd(0, ra2);
      n_checks++; if (rd2_a !== e) begin n_fail++; $display("FAIL random rd2_a n=%0d: got %h want %h", n, rd2_a, e); end
      e = exp_rd(1, ra1);
      n_checks++; if (rd1_b !== e) begin n_fail++; $display("FAIL random rd1_b n=%0d: got %h want %h", n, rd1_b, e); end
      e = exp_rd(1, ra2);
      n_checks++; if (rd2_b !== e) begin n_fail++; $display("FAIL random rd2_b n=%0d: got %h want %h", n, rd2_b, e); end
      tick();
      n_checks++;
      if (done_a !== m_done || done_b !== m_done || cnt_a !== m_cnt[0] || cnt_b !== m_cnt[1]) begin
        n_fail++; $display("FAIL random flags n=%0d: got done=%b/%b cnt=%0d/%0d want %b cnt=%0d/%0d",
                           n, done_a, done_b, cnt_a, cnt_b, m_done, m_cnt[0], m_cnt[1]);
      end
    end
    rst = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = 5'd0; wd = 32'h0; ra1 = 5'd0; ra2 = 5'd0;
    m_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 32; k++) m_regs[c][k] = 32'h0;
      m_cnt[c] = 8'd0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_bypass();
    test_reset_vs_write();
    test_wrap();
    test_walking_one();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
